// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit ALU: latches a command onto the ALU pins,
// waits a settle window, then samples and packs the result into a response.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [1:0]       alu_s,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic             alu_asc,
  input  logic [3:0]       alu_as,
  input  logic             alu_gt,
  input  logic             alu_eq,
  input  logic             alu_lt,
  input  logic [3:0]       alu_and,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_op,
  output logic [3:0]       rsp_data,
  output logic             rsp_carry,
  output logic [2:0]       rsp_cmp,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       alu_s_q, alu_s_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_op_q, rsp_op_d;
  logic [3:0]       rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [2:0]       rsp_cmp_q, rsp_cmp_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [CNT_W-1:0] done_q, done_d;

  logic [3:0]       pk_data;
  logic             pk_carry;
  logic [2:0]       pk_cmp;
  logic             pk_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid)     state_d = SETTLE;
      SETTLE:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
  end

  // Result selection keyed by the op already latched on the ALU select pins.
  always_comb begin
    pk_data  = 4'd0;
    pk_carry = 1'b0;
    pk_cmp   = 3'b000;
    pk_zero  = 1'b0;
    case (alu_s_q)
      2'b00, 2'b01: begin
        pk_data  = alu_as;
        pk_carry = alu_asc;
        pk_zero  = (alu_as == 4'd0);
      end
      2'b10: begin
        pk_cmp  = {alu_gt, alu_eq, alu_lt};
        pk_zero = alu_eq;
      end
      default: begin
        pk_data = alu_and;
        pk_zero = (alu_and == 4'd0);
      end
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    alu_s_d     = alu_s_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_cmp_d   = rsp_cmp_q;
    rsp_zero_d  = rsp_zero_q;
    done_d      = done_q;
    case (state_q)
      IDLE: begin
        alu_a_d = 4'd0;
        alu_b_d = 4'd0;
        if (cmd_valid) begin
          alu_s_d = cmd_op;
          alu_a_d = cmd_a;
          alu_b_d = cmd_b;
          cnt_d   = CNT_LOAD;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_op_d    = alu_s_q;
          rsp_data_d  = pk_data;
          rsp_carry_d = pk_carry;
          rsp_cmp_d   = pk_cmp;
          rsp_zero_d  = pk_zero;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_d      = done_q + CNT_W'(1);
          alu_a_d     = 4'd0;
          alu_b_d     = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      alu_s_q     <= 2'b00;
      alu_a_q     <= 4'd0;
      alu_b_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= 2'b00;
      rsp_data_q  <= 4'd0;
      rsp_carry_q <= 1'b0;
      rsp_cmp_q   <= 3'b000;
      rsp_zero_q  <= 1'b0;
      done_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      alu_s_q     <= alu_s_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_cmp_q   <= rsp_cmp_d;
      rsp_zero_q  <= rsp_zero_d;
      done_q      <= done_d;
    end
  end

  assign alu_s      = alu_s_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_cmp    = rsp_cmp_q;
  assign rsp_zero   = rsp_zero_q;
  assign done_count = done_q;

endmodule
